// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative multiply/divide unit owning the HI/LO register pair.
//
// Executes mult (shift-add) and div (restoring) one bit per cycle and serves
// mfhi/mflo reads. It stalls the core when a start or read arrives while busy.
//
// Parameters
//   WIDTH  operand width; HI and LO are WIDTH bits each
//   CNT_W  iteration counter width; 2**CNT_W must exceed WIDTH
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (aborts any op in flight)
//   start_mul  request multiply a*b (wins if start_div is also high)
//   start_div  request divide a/b
//   op_signed  signed operation (honoured only with MULDIV_SIGNED_EN)
//   a, b       operands (rs, rt), latched at the accepting edge
//   rd_hilo    mfhi/mflo read request
//   sel_hi     1 = read HI, 0 = read LO
//   rdata      selected HI or LO, combinational from the registers
//   busy       unit not idle
//   stall      start or read request while busy
//   done       one-cycle pulse in the first idle cycle after HI/LO update
//
// Configuration macro
//   MULDIV_SIGNED_EN  when defined, op_signed=1 runs on operand magnitudes and
//                     fixes the result sign in FIN; when undefined, op_signed
//                     is ignored and every op is unsigned.

module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             sel_hi,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi, lo, opb;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic               is_div;
  logic               start_any;
  logic [WIDTH-1:0]   opa_in, opb_in;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;

  assign start_any = start_mul | start_div;
  assign busy      = (state != S_IDLE);
  assign stall     = (start_any | rd_hilo) & busy;
  assign rdata     = sel_hi ? hi : lo;

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  assign a_neg  = op_signed & a[WIDTH-1];
  assign b_neg  = op_signed & b[WIDTH-1];
  assign opa_in = a_neg ? -a : a;
  assign opb_in = b_neg ? -b : b;

  // Divide by zero leaves the quotient as all ones; the remainder path still
  // restores the dividend's sign so HI reads back as the original a.
  always_comb begin
    fin_hi = acc[2*WIDTH-1:WIDTH];
    fin_lo = acc[WIDTH-1:0];
    if (is_div) begin
      if (neg_q) fin_lo = -acc[WIDTH-1:0];
      if (neg_r) fin_hi = -acc[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      {fin_hi, fin_lo} = -acc;
    end
  end
`else
  logic unused_sign;

  assign unused_sign = op_signed;
  assign opa_in      = a;
  assign opb_in      = b;

  always_comb begin
    fin_hi = acc[2*WIDTH-1:WIDTH];
    fin_lo = acc[WIDTH-1:0];
  end
`endif

  // Both ops share one accumulator: the upper half is the partial product or
  // partial remainder, the lower half the multiplier or dividend being
  // consumed. A zero divisor naturally yields quotient all ones and
  // remainder equal to the dividend.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = (div_shift >= {1'b0, opb});
    if (is_div) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_any) state_next = S_RUN;
      S_RUN:   if (cnt == CNT_W'(1)) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      done  <= (state == S_FIN);
      case (state)
        S_IDLE: begin
          if (start_any) begin
            acc    <= {{WIDTH{1'b0}}, opa_in};
            opb    <= opb_in;
            is_div <= ~start_mul;
            cnt    <= CNT_W'(WIDTH);
`ifdef MULDIV_SIGNED_EN
            neg_q  <= (a_neg ^ b_neg) & ~(~start_mul & (b == '0));
            neg_r  <= a_neg;
`endif
          end
        end
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
        end
        S_FIN: begin
          hi <= fin_hi;
          lo <= fin_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- directed self-checking bench for muldiv_seq (WIDTH=32).
// Inputs change on the falling edge or 1ns after the rising edge; outputs are
// sampled on the falling edge (plus 1ns after combinational input changes).

module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start_mul, start_div, op_signed, rd_hilo, sel_hi;
  logic [W-1:0] a, b, rdata;
  logic         busy, stall, done;

  int unsigned  pass_cnt = 0;
  int unsigned  total_cnt = 0;
  int           n;
  int           stall_bad;
  int           done_seen;

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_mul(start_mul), .start_div(start_div),
    .op_signed(op_signed), .a(a), .b(b), .rd_hilo(rd_hilo), .sel_hi(sel_hi),
    .rdata(rdata), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      pass_cnt++;
  endtask

  // Present a start for exactly one rising edge, assuming the unit is idle.
  task automatic issue(input logic mul, input logic sgn, input logic [W-1:0] va,
                       input logic [W-1:0] vb);
    @(negedge clk);
    start_mul = mul;
    start_div = ~mul;
    op_signed = sgn;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    start_mul = 1'b0;
    start_div = 1'b0;
  endtask

  // Count falling edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 1;
    @(negedge clk);
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic check_hilo(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
    sel_hi = 1'b1;
    #1 check({tag, "_hi"}, rdata, eh);
    sel_hi = 1'b0;
    #1 check({tag, "_lo"}, rdata, el);
  endtask

  initial begin
    reset = 1'b1; start_mul = 1'b0; start_div = 1'b0; op_signed = 1'b0;
    rd_hilo = 1'b0; sel_hi = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check_hilo("rst", 0, 0);
    reset = 1'b0;

    // 1: 7*6, done at edge WIDTH+2 counting the accepting edge
    issue(1'b1, 1'b0, 7, 6);
    wait_done(n);
    check("mul7x6_edges", n, 34);
    check("mul7x6_busy", busy, 0);
    check_hilo("mul7x6", 0, 42);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // 2: max unsigned operands
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    check("mulmax_edges", n, 34);
    check_hilo("mulmax", 32'hFFFF_FFFE, 32'h0000_0001);

    // 3: divide, then divide by zero
    issue(1'b0, 1'b0, 100, 7);
    wait_done(n);
    check("div100_7_edges", n, 34);
    check_hilo("div100_7", 2, 14);
    issue(1'b0, 1'b0, 5, 0);
    wait_done(n);
    check_hilo("div5_0", 5, 32'hFFFF_FFFF);

    // 4: read + div issued during RUN stall until the done cycle
    issue(1'b1, 1'b0, 32'h8000_0000, 6);
    n = 0;
    stall_bad = 0;
    done_seen = 0;
    while (n < 200 && done_seen == 0) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        rd_hilo = 1'b1; sel_hi = 1'b1; start_div = 1'b1; a = 20; b = 3;
      end
      #1;
      if (done) done_seen = 1;
      else if (n >= 3 && !stall) stall_bad++;
    end
    check("rd_stall_edges", n, 34);
    check("rd_stall_held", stall_bad, 0);
    check("rd_done_stall", stall, 0);
    check("rd_done_busy", busy, 0);
    check("rd_new_hi", rdata, 3);
    @(posedge clk);
    #1;
    start_div = 1'b0; rd_hilo = 1'b0;
    check("held_div_accepted", busy, 1);
    wait_done(n);
    check("held_div_edges", n, 34);
    check_hilo("held_div", 2, 6);

    // 5: reset in the middle of RUN
    issue(1'b1, 1'b0, 123456, 789);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check_hilo("abort", 0, 0);
    done_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("abort_no_done", done_seen, 0);
    issue(1'b1, 1'b0, 3, 3);
    wait_done(n);
    check("mul3x3_edges", n, 34);
    check_hilo("mul3x3", 0, 9);

    // 6: op_signed=1
`ifdef MULDIV_SIGNED_EN
    issue(1'b1, 1'b1, -32'sd7, 6);
    wait_done(n);
    check_hilo("smul", 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    issue(1'b0, 1'b1, -32'sd7, 2);
    wait_done(n);
    check("sdiv_edges", n, 34);
    check_hilo("sdiv", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 6);
    wait_done(n);
    check_hilo("smul_ignored", 5, 32'hFFFF_FFD6);
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 2);
    wait_done(n);
    check_hilo("sdiv_ignored", 1, 32'h7FFF_FFFC);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
